display_scan_ctrl: RTL and testbench
====================================

Name: display_scan_ctrl

Overview:
Time-multiplexing scheduler that shares one active-low 7-segment driver (seg_n/dp_n) between DIGITS digit sources, such as the adder/subtractor result digits. Uses an internal prescaler in place of a divided clock and runs entirely on clk_in. Sequences digits round-robin, inserts a blanking gap between digits to prevent ghosting, and snapshots each digit's nibble at display start.

Parameters:
DIGITS, 4, number of multiplexed digits (>=2)
DIV_LIMIT, 12000, clk_in cycles each digit is lit (>=1; 1 ms at 12 MHz)
BLANK_CYCLES, 16, clk_in cycles all anodes are off between digits (>=1)
CNT_W, 16, prescaler width; must hold max(DIV_LIMIT, BLANK_CYCLES)-1

Ports:
clk_in  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
enable  input  1  1 = scan, 0 = blank and park
digit_data  input  4*DIGITS  hex nibble per digit; digit i = [4i+3:4i]
dp_in  input  DIGITS  decimal point per digit, active-high
anode_n  output  DIGITS  digit select, active-low, one-hot-low or all 1
seg_n  output  7  {g,f,e,d,c,b,a}, active-low
dp_n  output  1  decimal point, active-low
digit_idx  output  clog2(DIGITS)  index of current/next digit
frame_done  output  1  one-cycle pulse when the last digit finishes

Behaviour:
- One clock domain. All outputs are registered. rst_n low asynchronously forces state IDLE, anode_n all 1, seg_n 7'h7F, dp_n 1, digit_idx 0, prescaler 0, frame_done 0.
- FSM states: IDLE, BLANK, SHOW. A single prescaler cnt is shared by BLANK and SHOW.
- IDLE: outputs blanked, cnt 0, idx 0. If enable=1, go to BLANK on the next edge.
- BLANK:
  - anode_n all 1, seg_n 7'h7F, dp_n 1.
  - cnt increments each cycle.
  - When cnt==BLANK_CYCLES-1: cnt<=0 and state<=SHOW. On the same edge, anode_n[idx]<=0, seg_n<=hex(digit_data nibble idx), dp_n<=~dp_in[idx].
- SHOW:
  - Outputs are held and are not updated from the inputs. Changes on digit_data/dp_in appear at the next SHOW entry for that digit.
  - When cnt==DIV_LIMIT-1:
    - cnt<=0 and state<=BLANK; outputs are blanked on the same edge.
    - idx<=idx+1, wrapping to 0 after DIGITS-1.
    - If idx was DIGITS-1, frame_done=1 for exactly that cycle.
- Timing:
  - Period per digit = BLANK_CYCLES+DIV_LIMIT clocks.
  - Frame period = DIGITS*(BLANK_CYCLES+DIV_LIMIT).
  - Latency from enable rise to first lit digit = 1+BLANK_CYCLES edges.
- enable=0 in any state: on the next edge go to IDLE, blank, idx 0, cnt 0, frame_done 0. Disabling in the same cycle a frame would end suppresses frame_done. Re-enabling always restarts at digit 0.
- Hex table for seg_n, nibble -> value:
  - 0:40, 1:79, 2:24, 3:30, 4:19, 5:12, 6:02, 7:78
  - 8:00, 9:10, A:08, b:03, C:46, d:21, E:06, F:0E
- Invariants:
  - At most one anode_n bit is 0 at any time.
  - anode_n is never 0 in IDLE/BLANK.
  - cnt never exceeds its state limit.
- Reset asserted mid-SHOW blanks immediately, without waiting for a clock edge. Release resumes in IDLE.

Test Plan:
(Params DIGITS=4, DIV_LIMIT=5, BLANK_CYCLES=2.)
1. rst_n=0 with enable=1, no clock edges -> anode_n=4'hF, seg_n=7'h7F, dp_n=1, frame_done=0. Release -> IDLE holds one edge, then BLANK.
2. digit_data=16'h3210, dp_in=4'b0100, enable from reset -> 2 blank cycles, then anode_n=1110/seg 40 for 5 cycles; then 1101/79; 1011/24 with dp_n=0; 0111/30. There are 2 blank cycles between digits.
3. Continuous scan -> frame_done pulses exactly 1 cycle every 28 cycles, on the edge leaving digit 3. digit_idx wraps 3->0.
4. digit_data changed mid-SHOW of digit 1 -> seg_n unchanged until digit 1 is next entered. Sweep all 16 nibbles to check the hex table.
5. enable=0 mid-SHOW of digit 2 -> next edge all blank, digit_idx=0, no frame_done. Re-enable -> digit 0 lit after 1+2 edges.
6. rst_n pulsed asynchronously mid-SHOW (between edges) -> outputs blank immediately. At no time is more than one anode_n bit low (assertion across all tests).

Source files
------------

// File: rtl/display_scan_ctrl.sv
// display_scan_ctrl: round-robin active-low 7-segment scanner with blanking gaps and per-digit snapshot
module display_scan_ctrl #(
  parameter int DIGITS = 4,
  parameter int DIV_LIMIT = 12000,
  parameter int BLANK_CYCLES = 16,
  parameter int CNT_W = 16,
  localparam int IW = DIGITS > 1 ? $clog2(DIGITS) : 1
) (
  input  logic              clk_in,
  input  logic              rst_n,
  input  logic              enable,
  input  logic [4*DIGITS-1:0] digit_data,
  input  logic [DIGITS-1:0] dp_in,
  output logic [DIGITS-1:0] anode_n,
  output logic [6:0]        seg_n,
  output logic              dp_n,
  output logic [IW-1:0]     digit_idx,
  output logic              frame_done
);
  typedef enum logic [1:0] {IDLE, BLANK, SHOW} state_t;
  localparam logic [6:0] HEX [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                      7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
  state_t state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [DIGITS-1:0] anode_q, anode_d;
  logic [6:0] seg_q, seg_d;
  logic dp_q, dp_d, fd_q, fd_d;
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    idx_d = idx_q;
    anode_d = anode_q;
    seg_d = seg_q;
    dp_d = dp_q;
    fd_d = 1'b0;
    if (!enable) begin
      state_d = IDLE;
      cnt_d = '0;
      idx_d = '0;
      anode_d = '1;
      seg_d = '1;
      dp_d = 1'b1;
    end else begin
      case (state_q)
        IDLE: state_d = BLANK;
        BLANK: begin
          anode_d = '1;
          seg_d = '1;
          dp_d = 1'b1;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CNT_W'(BLANK_CYCLES - 1)) begin
            state_d = SHOW;
            cnt_d = '0;
            anode_d = ~(DIGITS'(1) << idx_q);
            seg_d = HEX[digit_data[4*idx_q +: 4]];
            dp_d = ~dp_in[idx_q];
          end
        end
        SHOW: begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CNT_W'(DIV_LIMIT - 1)) begin
            state_d = BLANK;
            cnt_d = '0;
            anode_d = '1;
            seg_d = '1;
            dp_d = 1'b1;
            fd_d = idx_q == IW'(DIGITS - 1);
            idx_d = fd_d ? '0 : idx_q + 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end
  always_ff @(posedge clk_in or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q <= '0;
      idx_q <= '0;
      anode_q <= '1;
      seg_q <= '1;
      dp_q <= 1'b1;
      fd_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      idx_q <= idx_d;
      anode_q <= anode_d;
      seg_q <= seg_d;
      dp_q <= dp_d;
      fd_q <= fd_d;
    end
  assign anode_n = anode_q;
  assign seg_n = seg_q;
  assign dp_n = dp_q;
  assign digit_idx = idx_q;
  assign frame_done = fd_q;
endmodule

// File: tb/tb_display_scan_ctrl.sv
// tb_display_scan_ctrl: directed plus random checks of display_scan_ctrl against an elapsed-time model
module tb_display_scan_ctrl;
  localparam int DIG = 4, DIV = 5, BLK = 2, P = DIV + BLK;
  logic clk_in = 1'b0, clk_on = 1'b0, rst_n = 1'b1, enable = 1'b1;
  logic [15:0] digit_data = 16'h3210;
  logic [3:0] dp_in = 4'b0100;
  logic [3:0] anode_n;
  logic [6:0] seg_n;
  logic dp_n, frame_done;
  logic [1:0] digit_idx;
  int n_cmp = 0, n_err = 0;
  display_scan_ctrl #(.DIGITS(DIG), .DIV_LIMIT(DIV), .BLANK_CYCLES(BLK), .CNT_W(16)) dut (
    .clk_in(clk_in), .rst_n(rst_n), .enable(enable), .digit_data(digit_data), .dp_in(dp_in),
    .anode_n(anode_n), .seg_n(seg_n), .dp_n(dp_n), .digit_idx(digit_idx), .frame_done(frame_done)
  );
  always #5 clk_in = clk_on ? ~clk_in : clk_in;
  logic [6:0] hex_tbl [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
  int e;
  logic [6:0] snap_seg;
  logic snap_dp;
  always @(posedge clk_in or negedge rst_n)
    if (!rst_n) e <= 0;
    else if (!enable) e <= 0;
    else begin
      e <= e + 1;
      if (e % P == BLK) begin
        snap_seg <= hex_tbl[digit_data[4*((e/P)%DIG) +: 4]];
        snap_dp <= dp_in[(e/P)%DIG];
      end
    end
  int p, d;
  logic lit, exp_fd;
  logic [3:0] exp_anode;
  logic [6:0] exp_seg;
  logic exp_dp;
  logic [1:0] exp_idx;
  always_comb begin
    p = e - 1;
    d = e > 0 ? (p / P) % DIG : 0;
    lit = e > 0 && p % P >= BLK;
    exp_anode = lit ? ~(4'b1 << d) : 4'hF;
    exp_seg = lit ? snap_seg : 7'h7F;
    exp_dp = lit ? ~snap_dp : 1'b1;
    exp_idx = 2'(d);
    exp_fd = e > 1 && p % (P*DIG) == 0;
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %0h, want %0h", tag, obs, exp);
    end
  endtask
  task automatic check_model();
    chk("anode_n", 32'(anode_n), 32'(exp_anode));
    chk("seg_n", 32'(seg_n), 32'(exp_seg));
    chk("dp_n", 32'(dp_n), 32'(exp_dp));
    chk("digit_idx", 32'(digit_idx), 32'(exp_idx));
    chk("frame_done", 32'(frame_done), 32'(exp_fd));
    chk("one_hot_low", 32'($countones(~anode_n) <= 1), 32'd1);
  endtask
  task automatic step(input int n);
    repeat (n) begin
      @(negedge clk_in);
      check_model();
    end
  endtask
  task automatic wait_lit(input int want, input int pos);
    logic found = 1'b0;
    for (int k = 0; k < 200 && !found; k++) begin
      if (lit && d == want && p % P == pos) found = 1'b1;
      else step(1);
    end
    chk("wait_lit", 32'(found), 32'd1);
  endtask
  initial begin
    #1 rst_n = 1'b0;
    #1;
    chk("rst_anode", 32'(anode_n), 32'hF);
    chk("rst_seg", 32'(seg_n), 32'h7F);
    chk("rst_dp", 32'(dp_n), 32'd1);
    chk("rst_fd", 32'(frame_done), 32'd0);
    chk("rst_idx", 32'(digit_idx), 32'd0);
    clk_on = 1'b1;
    @(negedge clk_in);
    @(negedge clk_in);
    rst_n = 1'b1;
    for (int i = 1; i <= 60; i++) begin
      @(negedge clk_in);
      check_model();
      if (i == 1) chk("idle_then_blank", 32'(anode_n), 32'hF);
      if (i == 3) chk("d0_seg", 32'(seg_n), 32'h40);
      if (i == 3) chk("d0_anode", 32'(anode_n), 32'hE);
      if (i == 10) chk("d1_seg", 32'(seg_n), 32'h79);
      if (i == 17) chk("d2_anode", 32'(anode_n), 32'hB);
      if (i == 17) chk("d2_dp", 32'(dp_n), 32'd0);
      if (i == 24) chk("d3_seg", 32'(seg_n), 32'h30);
      if (i == 28 || i == 56) chk("fd_low", 32'(frame_done), 32'd0);
      if (i == 29 || i == 57) chk("fd_pulse", 32'(frame_done), 32'd1);
      if (i == 29) chk("idx_wrap", 32'(digit_idx), 32'd0);
    end
    wait_lit(1, BLK + 1);
    digit_data = 16'hFEDC;
    dp_in = 4'b1011;
    step(2 * P * DIG);
    for (int n = 0; n < 16; n++) begin
      digit_data = {4{4'(n)}};
      step(P * DIG);
    end
    wait_lit(2, BLK + 2);
    enable = 1'b0;
    step(1);
    chk("dis_anode", 32'(anode_n), 32'hF);
    chk("dis_idx", 32'(digit_idx), 32'd0);
    enable = 1'b1;
    step(3);
    chk("reen_anode", 32'(anode_n), 32'hE);
    wait_lit(3, P - 1);
    enable = 1'b0;
    step(1);
    chk("dis_no_fd", 32'(frame_done), 32'd0);
    enable = 1'b1;
    wait_lit(1, BLK + 1);
    @(posedge clk_in);
    #2 rst_n = 1'b0;
    #1;
    chk("async_anode", 32'(anode_n), 32'hF);
    chk("async_seg", 32'(seg_n), 32'h7F);
    check_model();
    @(negedge clk_in);
    rst_n = 1'b1;
    step(3);
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(0, 99) < 30) digit_data = 16'($urandom);
      if ($urandom_range(0, 99) < 20) dp_in = 4'($urandom);
      if ($urandom_range(0, 99) < 2) enable = ~enable;
      if ($urandom_range(0, 199) == 0) begin
        #2 rst_n = 1'b0;
        #1 check_model();
        #1 rst_n = 1'b1;
      end
      step(1);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
